// File: rtl/regfile_sb.sv
// Register bank with two registered read ports, one write port, write-first bypass
// and a per-register scoreboard that stalls reads of registers still awaiting writeback.
module regfile_sb #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 3,
    parameter bit ZERO_REG       = 1'b0,
    parameter bit RESET_IDENTITY = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       readEnable,
    input  logic [ADDR_WIDTH-1:0]      rs,
    input  logic [ADDR_WIDTH-1:0]      rt,
    output logic [DATA_WIDTH-1:0]      data1,
    output logic [DATA_WIDTH-1:0]      data2,
    output logic                       stall,
    input  logic                       RegWrite,
    input  logic [ADDR_WIDTH-1:0]      rd,
    input  logic [DATA_WIDTH-1:0]      dataToWrite,
    input  logic                       issueValid,
    input  logic [ADDR_WIDTH-1:0]      issueRd,
    output logic [(2**ADDR_WIDTH)-1:0] pending
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] value1;
    logic [DATA_WIDTH-1:0] value2;
    logic [DEPTH-1:0]      next_pending;
    logic                  write_en;
    logic                  busy1;
    logic                  busy2;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
        return ZERO_REG && (idx == '0);
    endfunction

    // Read value seen by decode: hardwired zero first, then the in-flight write, then storage.
    function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] idx);
        if (is_zero(idx))
            return '0;
        else if (RegWrite && (rd == idx))
            return dataToWrite;
        else
            return regs[idx];
    endfunction

    // A writeback landing this cycle satisfies the dependency on its register.
    function automatic logic is_busy(input logic [ADDR_WIDTH-1:0] idx);
        return pending[idx] && !(RegWrite && (rd == idx));
    endfunction

    always_comb begin
        write_en = RegWrite && !is_zero(rd);
        value1   = read_value(rs);
        value2   = read_value(rt);
        busy1    = is_busy(rs);
        busy2    = is_busy(rt);
        stall    = readEnable && (busy1 || busy2);
    end

    // A new issue outranks a same-cycle writeback so the newer producer stays tracked.
    always_comb begin
        next_pending = pending;
        for (int i = 0; i < DEPTH; i++) begin
            if (issueValid && (issueRd == ADDR_WIDTH'(i)) && !is_zero(issueRd))
                next_pending[i] = 1'b1;
            else if (RegWrite && (rd == ADDR_WIDTH'(i)))
                next_pending[i] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= RESET_IDENTITY ? DATA_WIDTH'(i) : '0;
            pending <= '0;
            data1   <= '0;
            data2   <= '0;
        end else begin
            if (write_en)
                regs[rd] <= dataToWrite;
            if (readEnable && !stall) begin
                data1 <= value1;
                data2 <= value2;
            end
            pending <= next_pending;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one default instance and one with the zero register enabled,
// both driven by the same stimulus and checked against hand-computed values.
module tb_regfile_sb;

    logic        clock;
    logic        reset;
    logic        readEnable;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        RegWrite;
    logic [2:0]  rd;
    logic [15:0] dataToWrite;
    logic        issueValid;
    logic [2:0]  issueRd;

    logic [15:0] data1;
    logic [15:0] data2;
    logic        stall;
    logic [7:0]  pending;
    logic [15:0] data1_z;
    logic [15:0] data2_z;
    logic        stall_z;
    logic [7:0]  pending_z;

    int vectors;
    int miscompares;

    regfile_sb u_dut (
        .clock(clock), .reset(reset), .readEnable(readEnable), .rs(rs), .rt(rt),
        .data1(data1), .data2(data2), .stall(stall), .RegWrite(RegWrite), .rd(rd),
        .dataToWrite(dataToWrite), .issueValid(issueValid), .issueRd(issueRd),
        .pending(pending)
    );

    regfile_sb #(.ZERO_REG(1'b1)) u_zero (
        .clock(clock), .reset(reset), .readEnable(readEnable), .rs(rs), .rt(rt),
        .data1(data1_z), .data2(data2_z), .stall(stall_z), .RegWrite(RegWrite), .rd(rd),
        .dataToWrite(dataToWrite), .issueValid(issueValid), .issueRd(issueRd),
        .pending(pending_z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of inputs; they settle 1 time unit after the preceding edge.
    task automatic applyStimulus(input logic rst, input logic re, input logic [2:0] s1,
                                 input logic [2:0] s2, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic iv, input logic [2:0] ia);
        reset       = rst;
        readEnable  = re;
        rs          = s1;
        rt          = s2;
        RegWrite    = we;
        rd          = wa;
        dataToWrite = wd;
        issueValid  = iv;
        issueRd     = ia;
        #1;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
        checkOutput("reset_data1", 32'(data1), 32'h0);
        checkOutput("reset_data2", 32'(data2), 32'h0);
        checkOutput("reset_pending", 32'(pending), 32'h0);

        applyStimulus(0, 1, 5, 7, 0, 0, 16'h0000, 0, 0);
        checkOutput("reset_stall", 32'(stall), 32'h0);
        step();
        checkOutput("identity_data1", 32'(data1), 32'h5);
        checkOutput("identity_data2", 32'(data2), 32'h7);

        applyStimulus(0, 0, 0, 0, 1, 2, 16'hBEEF, 0, 0);
        step();
        checkOutput("no_read_hold_data1", 32'(data1), 32'h5);
        applyStimulus(0, 1, 2, 0, 0, 0, 16'h0000, 0, 0);
        step();
        checkOutput("write_read_data1", 32'(data1), 32'hBEEF);
        checkOutput("write_read_data2", 32'(data2), 32'h0);

        applyStimulus(0, 1, 3, 1, 1, 3, 16'h1234, 0, 0);
        step();
        checkOutput("bypass_data1", 32'(data1), 32'h1234);
        checkOutput("bypass_data2", 32'(data2), 32'h1);
        applyStimulus(0, 1, 3, 5, 0, 0, 16'h0000, 0, 0);
        step();
        checkOutput("stored_data1", 32'(data1), 32'h1234);
        checkOutput("stored_data2", 32'(data2), 32'h5);

        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 1, 4);
        checkOutput("issue_same_cycle_pending", 32'(pending), 32'h0);
        step();
        checkOutput("issue_pending", 32'(pending), 32'h10);
        applyStimulus(0, 1, 4, 0, 0, 0, 16'h0000, 0, 0);
        checkOutput("pending_rs_stall", 32'(stall), 32'h1);
        step();
        checkOutput("stall_hold_data1", 32'(data1), 32'h1234);
        checkOutput("stall_hold_data2", 32'(data2), 32'h5);
        checkOutput("stall_keep_pending", 32'(pending), 32'h10);
        applyStimulus(0, 1, 4, 0, 1, 4, 16'h00AA, 0, 0);
        checkOutput("wb_clears_stall", 32'(stall), 32'h0);
        step();
        checkOutput("wb_bypass_data1", 32'(data1), 32'h00AA);
        checkOutput("wb_bypass_data2", 32'(data2), 32'h0);
        checkOutput("wb_clears_pending", 32'(pending), 32'h0);

        applyStimulus(0, 1, 6, 2, 1, 6, 16'h6666, 1, 6);
        checkOutput("issue_wb_stall", 32'(stall), 32'h0);
        step();
        checkOutput("issue_wb_data1", 32'(data1), 32'h6666);
        checkOutput("issue_wb_data2", 32'(data2), 32'hBEEF);
        checkOutput("issue_wb_pending", 32'(pending), 32'h40);
        applyStimulus(0, 0, 2, 6, 0, 0, 16'h0000, 0, 0);
        checkOutput("no_read_no_stall", 32'(stall), 32'h0);
        applyStimulus(0, 1, 2, 6, 0, 0, 16'h0000, 0, 0);
        checkOutput("pending_rt_stall", 32'(stall), 32'h1);
        step();
        checkOutput("rt_stall_hold_data2", 32'(data2), 32'hBEEF);
        applyStimulus(0, 0, 0, 0, 1, 6, 16'h7777, 0, 0);
        step();
        checkOutput("wb6_pending", 32'(pending), 32'h0);

        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 1, 4);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 1, 5);
        step();
        checkOutput("two_pending", 32'(pending), 32'h30);
        applyStimulus(1, 1, 6, 6, 1, 1, 16'hDEAD, 1, 2);
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0);
        checkOutput("midreset_pending", 32'(pending), 32'h0);
        checkOutput("midreset_data1", 32'(data1), 32'h0);
        checkOutput("midreset_data2", 32'(data2), 32'h0);
        applyStimulus(0, 1, 1, 6, 0, 0, 16'h0000, 0, 0);
        checkOutput("midreset_stall", 32'(stall), 32'h0);
        step();
        checkOutput("midreset_reg1", 32'(data1), 32'h1);
        checkOutput("midreset_reg6", 32'(data2), 32'h6);

        applyStimulus(0, 0, 0, 0, 1, 0, 16'hFFFF, 1, 0);
        step();
        checkOutput("zero_pending", 32'(pending_z), 32'h0);
        checkOutput("plain_reg0_pending", 32'(pending), 32'h1);
        applyStimulus(0, 1, 0, 0, 0, 0, 16'h0000, 0, 0);
        checkOutput("zero_stall", 32'(stall_z), 32'h0);
        checkOutput("plain_reg0_stall", 32'(stall), 32'h1);
        step();
        checkOutput("zero_data1", 32'(data1_z), 32'h0);
        checkOutput("zero_data2", 32'(data2_z), 32'h0);
        applyStimulus(0, 1, 0, 3, 1, 0, 16'hFFFF, 0, 0);
        checkOutput("plain_reg0_wb_stall", 32'(stall), 32'h0);
        step();
        checkOutput("zero_bypass_data1", 32'(data1_z), 32'h0);
        checkOutput("zero_data2_reg3", 32'(data2_z), 32'h3);
        checkOutput("plain_reg0_data1", 32'(data1), 32'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated scoreboard: the next generation of the processor's 8×16 register bank. It provides two registered read ports and one write port on a single clock edge, plus write-to-read bypass and per-register pending bits. The scoreboard lets the decode stage stall reads of registers whose producing instruction has not yet written back. It sits between decode (rs/rt/issue) and writeback (RegWrite/rd/dataToWrite).

## Interface
- DATA_WIDTH, 16, register width in bits
- ADDR_WIDTH, 3, register index width; depth = 2**ADDR_WIDTH
- ZERO_REG, 0, 1: register 0 reads as 0, ignores writes and issues
- RESET_IDENTITY, 1, 1: reset value of register i is i (truncated/zero-extended to DATA_WIDTH); 0: all registers reset to 0

Ports:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- readEnable  in  1  decode requests a read of rs/rt this cycle
- rs  in  ADDR_WIDTH  read port 1 index
- rt  in  ADDR_WIDTH  read port 2 index
- data1  out  DATA_WIDTH  registered read data, port 1
- data2  out  DATA_WIDTH  registered read data, port 2
- stall  out  1  combinational; read blocked by pending source
- RegWrite  in  1  writeback strobe
- rd  in  ADDR_WIDTH  write index
- dataToWrite  in  DATA_WIDTH  write data
- issueValid  in  1  an instruction writing issueRd is issued this cycle
- issueRd  in  ADDR_WIDTH  destination of issued instruction
- pending  out  2**ADDR_WIDTH  scoreboard bit vector, registered

## Operation
- Write: on posedge with RegWrite=1 and !reset, regs[rd] <= dataToWrite; suppressed when ZERO_REG=1 and rd=0.
- Read: on posedge with readEnable=1, stall=0, !reset: data1 <= value(rs), data2 <= value(rt). Otherwise data1/data2 hold.
- value(x): 0 if ZERO_REG=1 and x=0; else dataToWrite if RegWrite=1 and rd=x (bypass, write-first); else regs[x].
- Scoreboard per register i, on posedge:
  - set if issueValid=1 and issueRd=i (and not ZERO_REG-suppressed);
  - else cleared if RegWrite=1 and rd=i;
  - else hold. Issue and writeback to the same register in one cycle: bit stays set (new producer wins); register data still written.
- busy(x) = pending[x] and not (RegWrite=1 and rd=x); a same-cycle writeback satisfies the dependency.
- stall = readEnable and (busy(rs) or busy(rt)). Same-cycle issueValid does not affect stall in that cycle.
- Issue to a register that is already pending: bit stays set; no counting (single outstanding producer per register is decode's responsibility).
- RegWrite to a non-pending register: legal, writes data, pending unchanged (stays 0).

## Timing
- Reset (sync, one cycle): regs[i] <= RESET_IDENTITY ? i : 0; pending <= 0; data1, data2 <= 0. All other inputs ignored that cycle, including RegWrite and issueValid.
- Reset mid-operation: in-flight pending bits discarded; the first posedge after reset deasserts behaves normally.
- Read latency: 1 cycle (rs sampled at edge N, data1 valid after edge N).
- Write visible to read at the same edge via bypass; to regs array after the edge.
- pending updates visible 1 cycle after issue/writeback edge; stall is combinational from pending, readEnable, rs, rt, RegWrite, rd.
- Index wrap: indices are exactly ADDR_WIDTH bits; no out-of-range case.

## Test plan
- Reset, defaults (16/3/0/1): assert reset 1 cycle, then read rs=5, rt=7 -> data1=5, data2=7, pending=0, stall=0.
- Write then read: RegWrite=1, rd=2, data=0xBEEF; next cycle read rs=2 -> data1=0xBEEF; same-cycle read rs=rd=3 with data 0x1234 -> data1=0x1234 (bypass).
- Scoreboard stall: issue rd=4; next cycle readEnable, rs=4 -> stall=1, data1 holds; cycle with RegWrite rd=4 data 0x00AA and rs=4 -> stall=0, data1=0x00AA; pending[4]=0 afterwards.
- Simultaneous issue and writeback to rd=6 -> regs[6] updated, pending[6] remains 1; stall on rt=6 the next cycle.
- ZERO_REG=1: write rd=0 0xFFFF, issue rd=0 -> data1 from rs=0 reads 0, pending[0]=0, stall=0.
- Reset mid-operation: pending=0x30, assert reset with RegWrite=1 rd=1 -> pending=0, regs[1]=1, data1=data2=0.
